// File: rtl/wb_pkg.sv
// Purpose: shared Wishbone B4 cycle/burst type encodings and burst address stepping.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package wb_pkg;

  // Cycle type identifier values; 011-110 are reserved and handled as classic.
  typedef enum logic [2:0] {
    CLASSIC = 3'b000,
    CONST   = 3'b001,
    INCR    = 3'b010,
    EOB     = 3'b111
  } cti_t;

  typedef enum logic [1:0] {
    LINEAR = 2'b00,
    WRAP4  = 2'b01,
    WRAP8  = 2'b10,
    WRAP16 = 2'b11
  } bte_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Next word index of an incrementing burst. The caller zero-extends its
  // index to 32 bits and truncates the result. Linear uses an all-ones mask,
  // which collapses the wrap formula to a plain increment.
  function automatic logic [31:0] wb_next_adr(input logic [31:0] a, input bte_t bte);
    logic [31:0] m;
    case (bte)
      WRAP4:   m = 32'd3;
      WRAP8:   m = 32'd7;
      WRAP16:  m = 32'd15;
      default: m = '1;
    endcase
    return (a & ~m) | ((a + 32'd1) & m);
  endfunction

endpackage

// File: rtl/bram_sp.sv
// Purpose: single-port byte-enabled block RAM with synchronous, write-first read.
// Latency: dout updates one clock after en; a write returns the merged new word.
// Backpressure: none; an access is taken on every edge with en=1.
// Ports: clk; en (access enable); we_be (per-byte write enables);
//        addr (word index); din (write data); dout (registered read data).
module bram_sp #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2048
) (
  input  logic                            clk,
  input  logic                            en,
  input  logic [DATA_WIDTH/8-1:0]         we_be,
  input  logic [$clog2(DEPTH)-1:0]        addr,
  input  logic [DATA_WIDTH-1:0]           din,
  output logic [DATA_WIDTH-1:0]           dout
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] wr_word;

  // Merge enabled lanes of din over the stored word; this same value feeds
  // dout, which gives write-first behaviour without a second read.
  always_comb begin
    wr_word = mem[addr];
    for (int i = 0; i < DATA_WIDTH/8; i++) begin
      if (we_be[i]) wr_word[i*8 +: 8] = din[i*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      if (|we_be) mem[addr] <= wr_word;
      dout <= wr_word;
    end
  end

endmodule

// File: rtl/wb_bram_burst.sv
// Purpose: Wishbone B4 registered-feedback slave over a byte-enabled BRAM, CTI/BTE bursts.
// Latency: ack/err one cycle after stb; then one beat per cycle in const/incr bursts.
// Backpressure: stb low in a burst drops ack and restarts the access from the new adr.
// Ports: clk, rst_n (sync, active-low); cyc/stb/we/adr/sel/dat_ms/cti/bte from the
//        master; dat_sm read data, ack normal and err error termination to the master.
module wb_bram_burst
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADR_WIDTH     = 32,
  parameter int MEM_ADR_WIDTH = 11,
  parameter int MEM_WORDS     = 2**MEM_ADR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cyc,
  input  logic                    stb,
  input  logic                    we,
  input  logic [ADR_WIDTH-1:0]    adr,
  input  logic [DATA_WIDTH/8-1:0] sel,
  input  logic [DATA_WIDTH-1:0]   dat_ms,
  input  logic [2:0]              cti,
  input  logic [1:0]              bte,
  output logic [DATA_WIDTH-1:0]   dat_sm,
  output logic                    ack,
  output logic                    err
);

  localparam int SW  = DATA_WIDTH/8;
  localparam int LSB = $clog2(SW);
  localparam int RAW = $clog2(MEM_WORDS);
  // One extra bit on the burst index so a linear burst running off the end of
  // the array stays out of range instead of wrapping back to word 0.
  localparam int AW1 = MEM_ADR_WIDTH + 1;

  state_t                 state;
  logic [AW1-1:0]         a;
  logic                   rd_live;
  logic [DATA_WIDTH-1:0]  dat_hold;
  logic [DATA_WIDTH-1:0]  ram_dout;

  logic [MEM_ADR_WIDTH-1:0] word_in;
  logic [AW1-1:0]           word_ext;
  logic                     adr_ok;
  logic [31:0]              nxt32;
  logic [AW1-1:0]           a_nxt;
  logic                     nxt_ok;
  logic                     completing;
  logic                     wr_beat;
  logic                     unused_nxt;

  logic                     ram_en;
  logic [SW-1:0]            ram_we_be;
  logic [RAW-1:0]           ram_addr;
  logic                     rd_fire;

  assign word_in  = adr[LSB +: MEM_ADR_WIDTH];
  assign word_ext = {1'b0, word_in};
  assign adr_ok   = ((adr >> (LSB + MEM_ADR_WIDTH)) == '0) &&
                    (word_ext < AW1'(MEM_WORDS));

  assign nxt32      = wb_next_adr({{(32-AW1){1'b0}}, a}, bte_t'(bte));
  assign unused_nxt = ^nxt32[31:AW1];

  always_comb begin
    a_nxt = nxt32[AW1-1:0];
    // Keep the overflow bit sticky for linear bursts past the end.
    if (bte == LINEAR) a_nxt[AW1-1] = a_nxt[AW1-1] | a[AW1-1];
  end
  assign nxt_ok = (a_nxt < AW1'(MEM_WORDS));

  assign completing = (ack | err) & cyc & stb;
  assign wr_beat    = completing & ack & we;

  // RAM port steering: one access per edge. Reads prefetch the word the next
  // beat will return; burst writes do not read, so dat_sm only moves on reads
  // or on a constant-address write (write-first refresh).
  always_comb begin
    ram_en    = 1'b0;
    ram_we_be = '0;
    ram_addr  = word_in[RAW-1:0];
    rd_fire   = 1'b0;
    if (rst_n && cyc && stb) begin
      if (state == IDLE) begin
        if (!we && adr_ok) begin
          ram_en  = 1'b1;
          rd_fire = 1'b1;
        end
      end else if (completing) begin
        if (wr_beat) begin
          ram_en    = 1'b1;
          ram_we_be = sel;
          rd_fire   = (cti == CONST);
        end else if (!we) begin
          if (cti == CONST && ack) begin
            ram_en   = 1'b1;
            rd_fire  = 1'b1;
            ram_addr = a[RAW-1:0];
          end else if (cti == INCR && nxt_ok) begin
            ram_en   = 1'b1;
            rd_fire  = 1'b1;
            ram_addr = a_nxt[RAW-1:0];
          end
        end
      end
    end
  end

  bram_sp #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MEM_WORDS)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we_be (ram_we_be),
    .addr  (ram_addr),
    .din   (dat_ms),
    .dout  (ram_dout)
  );

  // The RAM output register has no reset, so dat_sm selects between it (when
  // the last edge performed a read) and a held copy of the previous value.
  assign dat_sm = rd_live ? ram_dout : dat_hold;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ack      <= 1'b0;
      err      <= 1'b0;
      a        <= '0;
      rd_live  <= 1'b0;
      dat_hold <= '0;
    end else begin
      dat_hold <= dat_sm;
      rd_live  <= rd_fire;
      if (!cyc) begin
        state <= IDLE;
        ack   <= 1'b0;
        err   <= 1'b0;
      end else if (state == IDLE) begin
        if (stb) begin
          a     <= word_ext;
          ack   <= adr_ok;
          err   <= !adr_ok;
          state <= ACTIVE;
        end
      end else if (!stb || !(ack || err)) begin
        state <= IDLE;
        ack   <= 1'b0;
        err   <= 1'b0;
      end else begin
        case (cti)
          CONST: ;
          INCR: begin
            a   <= a_nxt;
            ack <= nxt_ok;
            err <= !nxt_ok;
          end
          default: begin
            state <= IDLE;
            ack   <= 1'b0;
            err   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_bram_burst.sv
// Purpose: scoreboard bench for wb_bram_burst; a monitor checks every terminated beat.
// Latency: checks ack one cycle after stb and one beat per cycle in bursts.
// Backpressure: exercises master wait states and reset in the middle of a burst.
module tb_wb_bram_burst;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_ms;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_sm;
  logic        ack, err;

  int n_chk = 0;
  int n_bad = 0;

  typedef struct {
    logic        e;
    logic        ck;
    logic [31:0] d;
    string       nm;
  } exp_t;
  exp_t q[$];

  // Burst vectors: word index, data (write value / expected read), expected err.
  int          wl[8];
  logic [31:0] vl[8];
  logic        el[8];

  always #5 clk = ~clk;

  wb_bram_burst #(
    .DATA_WIDTH    (32),
    .ADR_WIDTH     (32),
    .MEM_ADR_WIDTH (11),
    .MEM_WORDS     (2048)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cyc    (cyc),
    .stb    (stb),
    .we     (we),
    .adr    (adr),
    .sel    (sel),
    .dat_ms (dat_ms),
    .cti    (cti),
    .bte    (bte),
    .dat_sm (dat_sm),
    .ack    (ack),
    .err    (err)
  );

  // Monitor: every beat the DUT terminates is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && cyc && stb && (ack || err)) begin
      n_chk++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_beat: ack=%0b err=%0b dat=%08h, no beat was expected",
                 ack, err, dat_sm);
      end else begin
        exp_t x;
        x = q.pop_front();
        if (err !== x.e || ack !== !x.e || (x.ck && dat_sm !== x.d)) begin
          n_bad++;
          $display("FAIL %s: ack=%0b err=%0b dat=%08h, want err=%0b dat=%08h",
                   x.nm, ack, err, dat_sm, x.e, x.d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", nm, act, exp);
    end
  endtask

  task automatic idle_bus();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; bte = 2'b00;
    @(posedge clk); #1;
  endtask

  // Present a new access and check it is terminated one cycle later.
  task automatic start(input logic w, input logic [31:0] ad, input logic [3:0] s,
                       input logic [31:0] d, input logic [2:0] c, input logic [1:0] b);
    cyc = 1'b1; stb = 1'b1; we = w; adr = ad; sel = s; dat_ms = d; cti = c; bte = b;
    @(posedge clk); #1;
    chk1("latency", 32'(ack | err), 32'd1);
  endtask

  // One beat: queue its expected response, then let its completing edge pass.
  task automatic beat(input logic [31:0] ad, input logic [31:0] d, input logic [2:0] c,
                      input logic e, input logic ck, input logic [31:0] xd, input string nm);
    exp_t x;
    adr = ad; dat_ms = d; cti = c;
    x.e = e; x.ck = ck; x.d = xd; x.nm = nm;
    q.push_back(x);
    @(posedge clk); #1;
  endtask

  task automatic single(input logic w, input logic [31:0] ad, input logic [3:0] s,
                        input logic [31:0] d, input logic e, input logic [31:0] xd,
                        input string nm);
    start(w, ad, s, d, 3'b000, 2'b00);
    beat(ad, d, 3'b000, e, !w && !e, xd, nm);
    chk1({nm, "_term_clr"}, 32'(ack | err), 32'd0);
    idle_bus();
  endtask

  // Burst over wl/vl/el: non-final beats use cti c, final beat is end-of-burst.
  task automatic burst(input logic w, input logic [1:0] b, input int n,
                       input logic [2:0] c, input string nm);
    int acks;
    acks = 0;
    start(w, 32'(wl[0] * 4), 4'hF, vl[0], (n == 1) ? 3'b111 : c, b);
    for (int k = 0; k < n; k++) begin
      if (ack || err) acks++;
      beat(32'(wl[k] * 4), vl[k], (k == n - 1) ? 3'b111 : c, el[k], !w && !el[k],
           vl[k], $sformatf("%s_%0d", nm, k));
    end
    chk1({nm, "_beats"}, 32'(acks), 32'(n));
    chk1({nm, "_term_low"}, 32'(ack | err), 32'd0);
    idle_bus();
  endtask

  initial begin
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; sel = '0;
    dat_ms = '0; cti = '0; bte = '0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_ack", 32'(ack), 32'd0);
    chk1("rst_err", 32'(err), 32'd0);
    chk1("rst_dat", dat_sm, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Classic write/read, then a single byte lane (byte 1) update.
    single(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0, "wr_full");
    single(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 32'hDEADBEEF, "rd_full");
    single(1'b1, 32'h10, 4'b0010, 32'h0000AA00, 1'b0, 32'h0, "wr_lane1");
    single(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 32'hDEADAAEF, "rd_lane1");

    // 8-beat linear incrementing write then read from 0x100 (words 64..71).
    for (int k = 0; k < 8; k++) begin
      wl[k] = 64 + k; vl[k] = 32'(k); el[k] = 1'b0;
    end
    burst(1'b1, 2'b00, 8, 3'b010, "incr_wr");
    burst(1'b0, 2'b00, 8, 3'b010, "incr_rd");

    // Fill words 4..7, then wrap4 read starting at word 6: order 6,7,4,5.
    for (int k = 0; k < 4; k++) begin
      wl[k] = 4 + k; vl[k] = 32'hC0DE0004 + 32'(k); el[k] = 1'b0;
    end
    burst(1'b1, 2'b00, 4, 3'b010, "fill4");
    wl[0] = 6; wl[1] = 7; wl[2] = 4; wl[3] = 5;
    for (int k = 0; k < 4; k++) vl[k] = 32'hC0DE0000 + 32'(wl[k]);
    burst(1'b0, 2'b01, 4, 3'b010, "wrap4_rd");

    // Constant-address read burst repeats the same word.
    wl[0] = 6; wl[1] = 6; wl[2] = 6; vl[0] = 32'hC0DE0006; vl[1] = 32'hC0DE0006;
    vl[2] = 32'hC0DE0006;
    burst(1'b0, 2'b00, 3, 3'b001, "const_rd");

    // Out-of-range: word 2048 errs on read and write and must not alias word 0.
    single(1'b1, 32'h0, 4'hF, 32'h12345678, 1'b0, 32'h0, "wr_w0");
    single(1'b0, 32'h2000, 4'hF, 32'h0, 1'b1, 32'h0, "oor_rd");
    single(1'b1, 32'h2000, 4'hF, 32'hBAD0BAD0, 1'b1, 32'h0, "oor_wr");
    single(1'b0, 32'h0, 4'hF, 32'h0, 1'b0, 32'h12345678, "rd_w0_intact");
    single(1'b0, 32'h80000010, 4'hF, 32'h0, 1'b1, 32'h0, "oor_hi_bit");

    // Linear burst running off the last word: second beat errs.
    single(1'b1, 32'h1FFC, 4'hF, 32'h7FF7FF00, 1'b0, 32'h0, "wr_last");
    wl[0] = 2047; wl[1] = 2048; vl[0] = 32'h7FF7FF00; vl[1] = 32'h0;
    el[0] = 1'b0; el[1] = 1'b1;
    burst(1'b0, 2'b00, 2, 3'b010, "edge_rd");
    el[1] = 1'b0;

    // Master wait state: stb low for 2 cycles after beat 1, restart at word 66.
    start(1'b0, 32'h100, 4'hF, 32'h0, 3'b010, 2'b00);
    beat(32'h100, 32'h0, 3'b010, 1'b0, 1'b1, 32'd0, "ws_0");
    beat(32'h104, 32'h0, 3'b010, 1'b0, 1'b1, 32'd1, "ws_1");
    stb = 1'b0;
    @(posedge clk); #1;
    chk1("ws_ack_drop", 32'(ack | err), 32'd0);
    @(posedge clk); #1;
    start(1'b0, 32'h108, 4'hF, 32'h0, 3'b010, 2'b00);
    beat(32'h108, 32'h0, 3'b010, 1'b0, 1'b1, 32'd2, "ws_2");
    beat(32'h10C, 32'h0, 3'b111, 1'b0, 1'b1, 32'd3, "ws_3");
    chk1("ws_term_low", 32'(ack | err), 32'd0);
    idle_bus();

    // Reset in the middle of an incrementing read.
    start(1'b0, 32'h100, 4'hF, 32'h0, 3'b010, 2'b00);
    beat(32'h100, 32'h0, 3'b010, 1'b0, 1'b1, 32'd0, "mr_0");
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk1("mr_ack", 32'(ack), 32'd0);
    chk1("mr_err", 32'(err), 32'd0);
    chk1("mr_dat", dat_sm, 32'd0);
    rst_n = 1'b1;
    idle_bus();
    single(1'b0, 32'h104, 4'hF, 32'h0, 1'b0, 32'd1, "mr_resume");

    repeat (2) @(posedge clk);
    #1;
    chk1("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
